// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, imem req/ack handshake, and a one-cycle
// execute strobe to the single-cycle 16-bit datapath with sticky fault detection.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC,
    output logic [15:0] Instruction,
    output logic        InstrValid,
    input  logic [15:0] pc_next,
    output logic        Fault,
    output logic [15:0] Retired
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_EXEC,
        ST_FAULT
    } state_t;

    localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] retired_q, retired_d;
    logic [15:0] tmo_q, tmo_d;
    logic        halt_seen_q, halt_seen_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            retired_q   <= '0;
            tmo_q       <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            retired_q   <= retired_d;
            tmo_q       <= tmo_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        tmo_d       = tmo_q;
        halt_seen_d = halt_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Halt) begin
                    state_d     = ST_REQ;
                    tmo_d       = '0;
                    halt_seen_d = 1'b0;
                end
            end
            ST_REQ: begin
                halt_seen_d = halt_seen_q | Halt;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_EXEC: begin
                retired_d = retired_q + 16'd1;
                if (pc_next[0]) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d = pc_next;
                    // Halt seen this cycle counts too, since it is still "since REQ entry".
                    if (halt_seen_q || Halt) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_REQ;
                        tmo_d       = '0;
                        halt_seen_d = 1'b0;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign InstrValid  = (state_q == ST_EXEC);
    assign Fault       = (state_q == ST_FAULT);
    assign Retired     = retired_q;

endmodule
